// File: rtl/decode_pkg.sv
// Shared MIPS32 decode definitions: encodings, one-hot op indices and the decoded bundle.
// Pure declarations, no logic; op width tracks whether the extended ISA is built in.
package decode_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL      = 6'h00;
    localparam logic [5:0] FN_JR       = 6'h08;
    localparam logic [5:0] FN_SYSCALL  = 6'h0C;
    localparam logic [5:0] FN_ADDU     = 6'h21;
    localparam logic [5:0] FN_SUBU     = 6'h23;
    localparam logic [5:0] FN_AND      = 6'h24;
    localparam logic [5:0] FN_OR       = 6'h25;
    localparam logic [5:0] FN_SLT      = 6'h2A;

    localparam int OP_ADDU    = 0;
    localparam int OP_SUBU    = 1;
    localparam int OP_JR      = 2;
    localparam int OP_SYSCALL = 3;
    localparam int OP_ORI     = 4;
    localparam int OP_LUI     = 5;
    localparam int OP_LW      = 6;
    localparam int OP_SW      = 7;
    localparam int OP_BEQ     = 8;
    localparam int OP_J       = 9;
    localparam int OP_JAL     = 10;
    localparam int OP_ADDIU   = 11;
    localparam int OP_SLT     = 12;
    localparam int OP_AND     = 13;
    localparam int OP_OR      = 14;
    localparam int OP_BNE     = 15;
    localparam int OP_SLL     = 16;
    localparam int OP_W_MAX   = 17;

    localparam logic [4:0] REG_RA = 5'd31;

    function automatic int op_width(input int ext_isa);
        return (ext_isa != 0) ? 17 : 11;
    endfunction

    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_HI} imm_kind_e;
    typedef enum logic [1:0] {WB_NONE, WB_RD, WB_RT, WB_RA} wb_sel_e;

    typedef struct packed {
        logic [31:0]         pc;
        logic [OP_W_MAX-1:0] op;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          shamt;
        logic [31:0]         imm;
        logic [25:0]         jtarget;
        logic                wb_en;
        logic [4:0]          wb_reg;
        logic                illegal;
    } dec_bundle_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational MIPS32 decoder: raw word + pc -> decoded bundle, unused fields forced to 0.
// Latency 0 (pure logic); no handshake, caller registers the result.
// Backpressure: none, output is a function of the inputs only.
module instr_decode_comb
    import decode_pkg::*;
#(
    parameter int EXT_ISA = 0
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output dec_bundle_t bundle
);

    logic [5:0]          opc;
    logic [5:0]          funct;
    logic                ext;
    logic [OP_W_MAX-1:0] op;
    logic                use_rs, use_rt, use_rd, use_sh, use_jt, illegal;
    imm_kind_e           imm_kind;
    wb_sel_e             wb_sel;
    logic [4:0]          wb_reg;

    assign opc   = instr[31:26];
    assign funct = instr[5:0];
    assign ext   = (EXT_ISA != 0);

    // Classify the word into an op plus which fields it actually carries.
    always_comb begin
        op       = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        use_rd   = 1'b0;
        use_sh   = 1'b0;
        use_jt   = 1'b0;
        illegal  = 1'b0;
        imm_kind = IMM_NONE;
        wb_sel   = WB_NONE;
        if (instr != 32'h0) begin
            case (opc)
                OPC_SPECIAL: begin
                    case (funct)
                        FN_ADDU:    begin op[OP_ADDU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; wb_sel = WB_RD; end
                        FN_SUBU:    begin op[OP_SUBU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; wb_sel = WB_RD; end
                        FN_JR:      begin op[OP_JR] = 1'b1; use_rs = 1'b1; end
                        FN_SYSCALL: op[OP_SYSCALL] = 1'b1;
                        FN_SLT:     if (ext) begin op[OP_SLT] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; wb_sel = WB_RD; end
                                    else illegal = 1'b1;
                        FN_AND:     if (ext) begin op[OP_AND] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; wb_sel = WB_RD; end
                                    else illegal = 1'b1;
                        FN_OR:      if (ext) begin op[OP_OR] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; use_rd = 1'b1; wb_sel = WB_RD; end
                                    else illegal = 1'b1;
                        FN_SLL:     if (ext) begin op[OP_SLL] = 1'b1; use_rt = 1'b1; use_rd = 1'b1; use_sh = 1'b1; wb_sel = WB_RD; end
                                    else illegal = 1'b1;
                        default:    illegal = 1'b1;
                    endcase
                end
                OPC_ORI:   begin op[OP_ORI] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_ZEXT; wb_sel = WB_RT; end
                OPC_LUI:   begin op[OP_LUI] = 1'b1; use_rt = 1'b1; imm_kind = IMM_HI; wb_sel = WB_RT; end
                OPC_LW:    begin op[OP_LW] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_SEXT; wb_sel = WB_RT; end
                OPC_SW:    begin op[OP_SW] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_SEXT; end
                OPC_BEQ:   begin op[OP_BEQ] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_SEXT; end
                OPC_J:     begin op[OP_J] = 1'b1; use_jt = 1'b1; end
                OPC_JAL:   begin op[OP_JAL] = 1'b1; use_jt = 1'b1; wb_sel = WB_RA; end
                OPC_ADDIU: if (ext) begin op[OP_ADDIU] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_SEXT; wb_sel = WB_RT; end
                           else illegal = 1'b1;
                OPC_BNE:   if (ext) begin op[OP_BNE] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm_kind = IMM_SEXT; end
                           else illegal = 1'b1;
                default:   illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (wb_sel)
            WB_RD:   wb_reg = instr[15:11];
            WB_RT:   wb_reg = instr[20:16];
            WB_RA:   wb_reg = REG_RA;
            default: wb_reg = 5'd0;
        endcase

        bundle         = '0;
        bundle.pc      = pc;
        bundle.op      = op;
        bundle.rs      = use_rs ? instr[25:21] : 5'd0;
        bundle.rt      = use_rt ? instr[20:16] : 5'd0;
        bundle.rd      = use_rd ? instr[15:11] : 5'd0;
        bundle.shamt   = use_sh ? instr[10:6]  : 5'd0;
        bundle.jtarget = use_jt ? instr[25:0]  : 26'd0;
        case (imm_kind)
            IMM_SEXT: bundle.imm = {{16{instr[15]}}, instr[15:0]};
            IMM_ZEXT: bundle.imm = {16'h0, instr[15:0]};
            IMM_HI:   bundle.imm = {instr[15:0], 16'h0};
            default:  bundle.imm = 32'h0;
        endcase
        // Writes to $0 are architecturally discarded, so they never request write-back.
        bundle.wb_reg  = wb_reg;
        bundle.wb_en   = (wb_reg != 5'd0);
        bundle.illegal = illegal;
    end

endmodule

// File: rtl/decode_queue.sv
// Decode-at-enqueue instruction buffer: DEPTH-entry circular FIFO of decoded bundles.
// Latency: accepted in cycle N, visible at the output in N+1 at the earliest.
// Backpressure: in_ready = (count < DEPTH), independent of out_ready; flush drops everything.
module decode_queue
    import decode_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int EXT_ISA = 0,
    localparam int OP_W    = op_width(EXT_ISA),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [OP_W-1:0]  out_op,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [31:0]      out_imm,
    output logic [25:0]      out_jtarget,
    output logic             out_wb_en,
    output logic [4:0]       out_wb_reg,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    dec_bundle_t      mem_q [DEPTH];
    dec_bundle_t      dec_bundle;
    dec_bundle_t      head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic             stray_op;

    instr_decode_comb #(.EXT_ISA(EXT_ISA)) u_dec (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec_bundle)
    );

    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_bundle;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    // Op bits beyond OP_W cannot come from this decoder; surface them as illegal rather than drop them.
    if (OP_W < OP_W_MAX) begin : g_stray
        assign stray_op = |head.op[OP_W_MAX-1:OP_W];
    end else begin : g_no_stray
        assign stray_op = 1'b0;
    end

    assign out_pc      = head.pc;
    assign out_op      = head.op[OP_W-1:0];
    assign out_rs      = head.rs;
    assign out_rt      = head.rt;
    assign out_rd      = head.rd;
    assign out_shamt   = head.shamt;
    assign out_imm     = head.imm;
    assign out_jtarget = head.jtarget;
    assign out_wb_en   = head.wb_en;
    assign out_wb_reg  = head.wb_reg;
    assign out_illegal = head.illegal | stray_op;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: three instances (base/4, ext/3, ext/1) against a queue-based reference.
module tb_decode_queue;

    localparam int NDUT = 3;
    localparam int DEPS [NDUT] = '{4, 3, 1};
    localparam int EXTS [NDUT] = '{0, 1, 1};

    // Op-index sets, one bit per op index.
    localparam int RS_M  = (1<<0)|(1<<1)|(1<<2)|(1<<4)|(1<<6)|(1<<7)|(1<<8)|(1<<11)|(1<<12)|(1<<13)|(1<<14)|(1<<15);
    localparam int RT_M  = (1<<0)|(1<<1)|(1<<4)|(1<<5)|(1<<6)|(1<<7)|(1<<8)|(1<<11)|(1<<12)|(1<<13)|(1<<14)|(1<<15)|(1<<16);
    localparam int RD_M  = (1<<0)|(1<<1)|(1<<12)|(1<<13)|(1<<14)|(1<<16);
    localparam int SH_M  = (1<<16);
    localparam int JT_M  = (1<<9)|(1<<10);
    localparam int SX_M  = (1<<6)|(1<<7)|(1<<8)|(1<<11)|(1<<15);
    localparam int ZX_M  = (1<<4);
    localparam int HI_M  = (1<<5);
    localparam int WRT_M = (1<<4)|(1<<5)|(1<<6)|(1<<11);

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] op;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] imm;
        logic [25:0] jt;
        logic        wbe;
        logic [4:0]  wbr;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        int          dut;
        int          opb;
        logic        ill;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] imm;
        logic [25:0] jt;
        logic        wbe;
        logic [4:0]  wbr;
    } dv_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid;
    logic [31:0] in_instr, in_pc;
    logic [2:0]  ordy;

    logic        o_inr [NDUT];
    logic        o_vld [NDUT];
    logic [31:0] o_pc  [NDUT];
    logic [16:0] o_op  [NDUT];
    logic [4:0]  o_rs  [NDUT];
    logic [4:0]  o_rt  [NDUT];
    logic [4:0]  o_rd  [NDUT];
    logic [4:0]  o_sh  [NDUT];
    logic [31:0] o_imm [NDUT];
    logic [25:0] o_jt  [NDUT];
    logic        o_wbe [NDUT];
    logic [4:0]  o_wbr [NDUT];
    logic        o_ill [NDUT];
    logic [4:0]  o_cnt [NDUT];

    exp_t mq [NDUT][$];
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CW = $clog2(DEPS[g] + 1);
        localparam int OW = (EXTS[g] != 0) ? 17 : 11;
        logic [CW-1:0] cnt;
        logic [OW-1:0] op;
        decode_queue #(.DEPTH(DEPS[g]), .EXT_ISA(EXTS[g])) u_dut (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(in_valid), .in_ready(o_inr[g]), .in_instr(in_instr), .in_pc(in_pc),
            .out_valid(o_vld[g]), .out_ready(ordy[g]), .out_pc(o_pc[g]), .out_op(op),
            .out_rs(o_rs[g]), .out_rt(o_rt[g]), .out_rd(o_rd[g]), .out_shamt(o_sh[g]),
            .out_imm(o_imm[g]), .out_jtarget(o_jt[g]), .out_wb_en(o_wbe[g]),
            .out_wb_reg(o_wbr[g]), .out_illegal(o_ill[g]), .count(cnt)
        );
        assign o_op[g]  = 17'(op);
        assign o_cnt[g] = 5'(cnt);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit has(input int m, input int i);
        return ((m >> i) & 1) != 0;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input int ext);
        exp_t        e;
        int          idx;
        logic [15:0] i16;
        e     = '0;
        e.pc  = pc;
        idx   = -1;
        i16   = w[15:0];
        if (w == 32'h0) return e;
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h21: idx = 0;  6'h23: idx = 1;  6'h08: idx = 2;  6'h0C: idx = 3;
                6'h2A: idx = 12; 6'h24: idx = 13; 6'h25: idx = 14; 6'h00: idx = 16;
                default: idx = -1;
            endcase
        end else begin
            case (w[31:26])
                6'h0D: idx = 4;  6'h0F: idx = 5;  6'h23: idx = 6;  6'h2B: idx = 7;
                6'h04: idx = 8;  6'h02: idx = 9;  6'h03: idx = 10; 6'h09: idx = 11;
                6'h05: idx = 15;
                default: idx = -1;
            endcase
        end
        if (idx >= 11 && ext == 0) idx = -1;
        if (idx < 0) begin
            e.ill = 1'b1;
            return e;
        end
        e.op = 17'd1 << idx;
        if (has(RS_M, idx)) e.rs = w[25:21];
        if (has(RT_M, idx)) e.rt = w[20:16];
        if (has(RD_M, idx)) e.rd = w[15:11];
        if (has(SH_M, idx)) e.sh = w[10:6];
        if (has(JT_M, idx)) e.jt = w[25:0];
        if (has(SX_M, idx)) e.imm = 32'($signed(i16));
        if (has(ZX_M, idx)) e.imm = 32'(i16);
        if (has(HI_M, idx)) e.imm = 32'(i16) << 16;
        if (has(RD_M, idx))       e.wbr = w[15:11];
        else if (has(WRT_M, idx)) e.wbr = w[20:16];
        else if (idx == 10)       e.wbr = 5'd31;
        e.wbe = (e.wbr != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0;
        if (r >= 2 && r <= 4) begin
            w[31:26] = 6'h00;
            case ($urandom_range(0, 8))
                0: w[5:0] = 6'h21; 1: w[5:0] = 6'h23; 2: w[5:0] = 6'h08;
                3: w[5:0] = 6'h0C; 4: w[5:0] = 6'h2A; 5: w[5:0] = 6'h24;
                6: w[5:0] = 6'h25; 7: w[5:0] = 6'h00; default: w[5:0] = 6'h3F;
            endcase
        end else if (r >= 5) begin
            case ($urandom_range(0, 9))
                0: w[31:26] = 6'h0D; 1: w[31:26] = 6'h0F; 2: w[31:26] = 6'h23;
                3: w[31:26] = 6'h2B; 4: w[31:26] = 6'h04; 5: w[31:26] = 6'h02;
                6: w[31:26] = 6'h03; 7: w[31:26] = 6'h09; 8: w[31:26] = 6'h05;
                default: w[31:26] = 6'h3F;
            endcase
        end
        if ($urandom_range(0, 3) == 0) w[20:16] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[15:11] = 5'd0;
        return w;
    endfunction

    // Compare every DUT with its model at mid-cycle, then advance the models by one clock.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            exp_t h;
            int   sz;
            sz = mq[k].size();
            h  = (sz > 0) ? mq[k][0] : '0;
            chk($sformatf("d%0d.out_valid", k), 64'(o_vld[k]), 64'(sz > 0));
            chk($sformatf("d%0d.in_ready", k), 64'(o_inr[k]), 64'(sz < DEPS[k]));
            chk($sformatf("d%0d.count", k), 64'(o_cnt[k]), 64'(sz));
            chk($sformatf("d%0d.pc", k), 64'(o_pc[k]), 64'(h.pc));
            chk($sformatf("d%0d.op", k), 64'(o_op[k]), 64'(h.op));
            chk($sformatf("d%0d.regs", k), 64'({o_rs[k], o_rt[k], o_rd[k], o_sh[k]}), 64'({h.rs, h.rt, h.rd, h.sh}));
            chk($sformatf("d%0d.imm", k), 64'(o_imm[k]), 64'(h.imm));
            chk($sformatf("d%0d.jtarget", k), 64'(o_jt[k]), 64'(h.jt));
            chk($sformatf("d%0d.wb", k), 64'({o_wbe[k], o_wbr[k]}), 64'({h.wbe, h.wbr}));
            chk($sformatf("d%0d.illegal", k), 64'(o_ill[k]), 64'(h.ill));
            if (reset || flush) begin
                mq[k].delete();
            end else begin
                if (sz > 0 && ordy[k]) void'(mq[k].pop_front());
                if (in_valid && sz < DEPS[k]) mq[k].push_back(ref_decode(in_instr, in_pc, EXTS[k]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    dv_t dv [7];

    initial begin
        dv[0] = '{32'h34058000, 0, 4,  1'b0, 5'd0,  5'd5, 5'd0, 5'd0, 32'h00008000, 26'h0,       1'b1, 5'd5};
        dv[1] = '{32'h8FA8FFFC, 0, 6,  1'b0, 5'd29, 5'd8, 5'd0, 5'd0, 32'hFFFFFFFC, 26'h0,       1'b1, 5'd8};
        dv[2] = '{32'h3C000001, 0, 5,  1'b0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h00010000, 26'h0,       1'b0, 5'd0};
        dv[3] = '{32'h0C100000, 0, 10, 1'b0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,        26'h0100000, 1'b1, 5'd31};
        dv[4] = '{32'h00000000, 0, -1, 1'b0, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,        26'h0,       1'b0, 5'd0};
        dv[5] = '{32'h00031100, 0, -1, 1'b1, 5'd0,  5'd0, 5'd0, 5'd0, 32'h0,        26'h0,       1'b0, 5'd0};
        dv[6] = '{32'h00031100, 1, 16, 1'b0, 5'd0,  5'd3, 5'd2, 5'd4, 32'h0,        26'h0,       1'b1, 5'd2};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; ordy = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // Known encodings, one at a time through empty queues.
        ordy = 3'b111;
        for (int i = 0; i < 7; i++) begin
            int d;
            d        = dv[i].dut;
            in_valid = 1'b1;
            in_instr = dv[i].w;
            in_pc    = 32'h0040_0000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d.valid", i), 64'(o_vld[d]), 64'd1);
            chk($sformatf("vec%0d.op", i), 64'(o_op[d]), (dv[i].opb < 0) ? 64'd0 : (64'd1 << dv[i].opb));
            chk($sformatf("vec%0d.illegal", i), 64'(o_ill[d]), 64'(dv[i].ill));
            chk($sformatf("vec%0d.rs", i), 64'(o_rs[d]), 64'(dv[i].rs));
            chk($sformatf("vec%0d.rt", i), 64'(o_rt[d]), 64'(dv[i].rt));
            chk($sformatf("vec%0d.rd", i), 64'(o_rd[d]), 64'(dv[i].rd));
            chk($sformatf("vec%0d.shamt", i), 64'(o_sh[d]), 64'(dv[i].sh));
            chk($sformatf("vec%0d.imm", i), 64'(o_imm[d]), 64'(dv[i].imm));
            chk($sformatf("vec%0d.jtarget", i), 64'(o_jt[d]), 64'(dv[i].jt));
            chk($sformatf("vec%0d.wb_en", i), 64'(o_wbe[d]), 64'(dv[i].wbe));
            chk($sformatf("vec%0d.wb_reg", i), 64'(o_wbr[d]), 64'(dv[i].wbr));
            step();
        end

        // Fill with the consumer stalled, then drain in order.
        ordy = 3'b000;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = rand_word();
            in_pc    = 32'h0001_0000 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        chk("fill.count", 64'(o_cnt[0]), 64'd4);
        chk("fill.in_ready", 64'(o_inr[0]), 64'd0);
        ordy = 3'b111;
        for (int i = 0; i < 6; i++) step();

        // Flush at count 3 with a word offered in the same cycle.
        ordy = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = rand_word();
            in_pc    = 32'h0002_0000 + 32'(i * 4);
            step();
        end
        chk("flush.pre_count", 64'(o_cnt[0]), 64'd3);
        flush    = 1'b1;
        in_instr = 32'h3405BEEF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.count", 64'(o_cnt[0]), 64'd0);
        chk("flush.out_valid", 64'(o_vld[0]), 64'd0);
        ordy = 3'b111;
        for (int i = 0; i < 3; i++) step();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_word();
            in_pc    = $urandom;
            ordy     = 3'($urandom);
            flush    = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; ordy = 3'b111;
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
